cas_key_loader: RTL and testbench



---
 rtl/cas_key_loader_if.sv | 25 ++
 rtl/cas_key_loader.sv | 129 ++++++++++++
 tb/tb_cas_key_loader.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/cas_key_loader_if.sv
// Serial key-load link and committed-key bus between a key source and cas_key_loader.
// The master drives the frame, the slave (loader) returns the key and status.
interface cas_key_loader_if #(
    parameter int KEY_W = 64
);
    logic             key_start;
    logic             key_sen;
    logic             key_sdi;
    logic [KEY_W-1:0] keyinput;
    logic             key_valid;
    logic             busy;
    logic             load_err;
    logic             lockout;
    logic [3:0]       retry_cnt;

    modport master (
        output key_start, key_sen, key_sdi,
        input  keyinput, key_valid, busy, load_err, lockout, retry_cnt
    );

    modport slave (
        input  key_start, key_sen, key_sdi,
        output keyinput, key_valid, busy, load_err, lockout, retry_cnt
    );
endinterface

// File: rtl/cas_key_loader.sv
// One-time key loader for a CAS-Lock locked core: receives a header/key/CRC-8 serial
// frame, commits the key once, and locks out after MAX_RETRY rejected frames.
module cas_key_loader #(
    parameter int         KEY_W     = 64,
    parameter logic [7:0] HDR       = 8'hA5,
    parameter int         MAX_RETRY = 4
) (
    input  logic           clk,
    input  logic           rst,
    cas_key_loader_if.slave bus
);
    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_HDR     = 3'd1;
    localparam logic [2:0] S_KEY     = 3'd2;
    localparam logic [2:0] S_CRC     = 3'd3;
    localparam logic [2:0] S_COMMIT  = 3'd4;
    localparam logic [2:0] S_LOADED  = 3'd5;
    localparam logic [2:0] S_LOCKOUT = 3'd6;

    localparam int CNT_W = $clog2(KEY_W);

    logic [2:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [7:0]       r_crc;
    logic [7:0]       r_shift;
    logic [KEY_W-1:0] r_staging;
    logic [KEY_W-1:0] r_key;
    logic             r_valid;
    logic             r_err;
    logic [3:0]       r_retry;

    logic       w_in_frame;
    logic       w_restart;
    logic       w_last_byte_bit;
    logic       w_reject;
    logic [7:0] w_byte;
    logic [7:0] w_crc_next;
    logic [3:0] w_retry_inc;

    assign w_in_frame      = (r_state == S_HDR) || (r_state == S_KEY) || (r_state == S_CRC);
    assign w_restart       = bus.key_start && (w_in_frame || (r_state == S_IDLE));
    assign w_byte          = {r_shift[6:0], bus.key_sdi};
    assign w_crc_next      = {r_crc[6:0], 1'b0} ^ ((r_crc[7] ^ bus.key_sdi) ? 8'h07 : 8'h00);
    assign w_retry_inc     = r_retry + 4'd1;
    assign w_last_byte_bit = bus.key_sen && (r_cnt == CNT_W'(7));
    // A bad header or bad CRC is only judged on the 8th bit of that field.
    assign w_reject        = !w_restart && w_last_byte_bit &&
                             (((r_state == S_HDR) && (w_byte != HDR)) ||
                              ((r_state == S_CRC) && (w_byte != r_crc)));

    // NOTE: all state below is registered with non-blocking assignments so every branch
    // reads the pre-edge values; the staging register is reset too, so no stale key survives.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_crc     <= '0;
            r_shift   <= '0;
            r_staging <= '0;
            r_key     <= '0;
            r_valid   <= 1'b0;
            r_err     <= 1'b0;
            r_retry   <= '0;
        end else begin
            r_err <= 1'b0;
            if (w_restart) begin
                r_state   <= S_HDR;
                r_crc     <= '0;
                r_staging <= '0;
                r_shift   <= {7'b0, bus.key_sdi};
                r_cnt     <= bus.key_sen ? CNT_W'(1) : '0;
            end else if (w_reject) begin
                r_err     <= 1'b1;
                r_retry   <= w_retry_inc;
                r_staging <= '0;
                r_cnt     <= '0;
                r_state   <= (w_retry_inc == 4'(MAX_RETRY)) ? S_LOCKOUT : S_IDLE;
            end else begin
                case (r_state)
                    S_HDR: if (bus.key_sen) begin
                        r_shift <= w_byte;
                        if (r_cnt == CNT_W'(7)) begin
                            r_state <= S_KEY;
                            r_cnt   <= '0;
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                    S_KEY: if (bus.key_sen) begin
                        r_staging[r_cnt] <= bus.key_sdi;
                        r_crc            <= w_crc_next;
                        if (r_cnt == CNT_W'(KEY_W - 1)) begin
                            r_state <= S_CRC;
                            r_cnt   <= '0;
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                    S_CRC: if (bus.key_sen) begin
                        r_shift <= w_byte;
                        if (r_cnt == CNT_W'(7)) begin
                            r_state <= S_COMMIT;
                            r_cnt   <= '0;
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                    S_COMMIT: begin
                        r_key   <= r_staging;
                        r_valid <= 1'b1;
                        r_state <= S_LOADED;
                    end
                    S_LOCKOUT: begin
                        r_key   <= '0;
                        r_valid <= 1'b0;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.keyinput  = r_key;
    assign bus.key_valid = r_valid;
    assign bus.busy      = w_in_frame || (r_state == S_COMMIT);
    assign bus.load_err  = r_err;
    assign bus.lockout   = (r_state == S_LOCKOUT);
    assign bus.retry_cnt = r_retry;
endmodule

// File: tb/tb_cas_key_loader.sv
// Directed bench for cas_key_loader: good/bad frames, lockout, one-time commit,
// mid-frame restart and mid-frame reset.
module tb_cas_key_loader;
    localparam logic [63:0] K1 = 64'h5A3C_F000_1234_8E61;
    localparam logic [63:0] K2 = 64'hDEAD_BEEF_0BAD_F00D;
    localparam logic [63:0] K3 = 64'h0123_4567_89AB_CDEF;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    cas_key_loader_if #(.KEY_W(64)) bus ();

    cas_key_loader #(.KEY_W(64), .HDR(8'hA5), .MAX_RETRY(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Spec CRC-8: poly 0x07, init 0, key bit n fed n-th.
    function automatic logic [7:0] crc8_ref(input logic [63:0] k);
        logic [7:0] c = 8'h00;
        for (int n = 0; n < 64; n++) begin
            c = {c[6:0], 1'b0} ^ ((c[7] ^ k[n]) ? 8'h07 : 8'h00);
        end
        return c;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b, input bit gaps);
        if (gaps) begin
            repeat ($urandom_range(0, 2)) begin
                bus.key_sen = 1'b0;
                tick();
            end
        end
        bus.key_sen = 1'b1;
        bus.key_sdi = b;
        tick();
        bus.key_sen = 1'b0;
    endtask

    task automatic send_hdr(input logic [7:0] h, input bit gaps, input bit combo);
        bus.key_start = 1'b1;
        bus.key_sen   = combo;
        bus.key_sdi   = combo ? h[7] : 1'b0;
        tick();
        bus.key_start = 1'b0;
        bus.key_sen   = 1'b0;
        for (int i = combo ? 6 : 7; i >= 0; i--) send_bit(h[i], gaps);
    endtask

    task automatic send_key(input logic [63:0] k, input int nbits, input bit gaps);
        for (int i = 0; i < nbits; i++) send_bit(k[i], gaps);
    endtask

    task automatic send_crc(input logic [7:0] c, input int nbits, input bit gaps);
        for (int i = 7; i > 7 - nbits; i--) send_bit(c[i], gaps);
    endtask

    task automatic send_frame(input logic [7:0] h, input logic [63:0] k, input logic [7:0] c,
                              input bit gaps, input bit combo);
        send_hdr(h, gaps, combo);
        send_key(k, 64, gaps);
        send_crc(c, 8, gaps);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.key_start = 1'b0;
        bus.key_sen   = 1'b0;
        bus.key_sdi   = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        bus.key_start = 1'b0;
        bus.key_sen   = 1'b0;
        bus.key_sdi   = 1'b0;
        do_reset();
        check("rst_keyinput", bus.keyinput, 64'h0);
        check("rst_valid", 64'(bus.key_valid), 64'd0);
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_lockout", 64'(bus.lockout), 64'd0);
        check("rst_retry", 64'(bus.retry_cnt), 64'd0);

        // 1: zero key, CRC 0x00
        send_frame(8'hA5, 64'h0, 8'h00, 1'b0, 1'b0);
        check("t1_valid_early", 64'(bus.key_valid), 64'd0);
        check("t1_busy_commit", 64'(bus.busy), 64'd1);
        tick();
        check("t1_valid", 64'(bus.key_valid), 64'd1);
        check("t1_keyinput", bus.keyinput, 64'h0);
        check("t1_busy_after", 64'(bus.busy), 64'd0);

        // 2: bad header, then K1 with random stalls
        do_reset();
        send_hdr(8'hA4, 1'b0, 1'b0);
        check("t2_load_err", 64'(bus.load_err), 64'd1);
        check("t2_retry", 64'(bus.retry_cnt), 64'd1);
        check("t2_busy", 64'(bus.busy), 64'd0);
        tick();
        check("t2_err_pulse", 64'(bus.load_err), 64'd0);
        check("t2_key_zero", bus.keyinput, 64'h0);
        send_frame(8'hA5, K1, crc8_ref(K1), 1'b1, 1'b0);
        tick();
        check("t2_valid", 64'(bus.key_valid), 64'd1);
        check("t2_keyinput", bus.keyinput, K1);

        // 4: second frame after commit is ignored
        send_frame(8'hA5, K2, crc8_ref(K2), 1'b0, 1'b0);
        tick();
        check("t4_keyinput", bus.keyinput, K1);
        check("t4_valid", 64'(bus.key_valid), 64'd1);
        check("t4_busy", 64'(bus.busy), 64'd0);

        // 3: four bad CRCs lead to lockout
        do_reset();
        for (int i = 0; i < 4; i++) begin
            send_frame(8'hA5, 64'h0, 8'h01, 1'b0, 1'b0);
            check("t3_load_err", 64'(bus.load_err), 64'd1);
            check("t3_retry", 64'(bus.retry_cnt), 64'(i + 1));
            check("t3_lockout", 64'(bus.lockout), (i == 3) ? 64'd1 : 64'd0);
            tick();
            check("t3_err_pulse", 64'(bus.load_err), 64'd0);
        end
        send_frame(8'hA5, K1, crc8_ref(K1), 1'b0, 1'b0);
        tick();
        check("t3_locked_valid", 64'(bus.key_valid), 64'd0);
        check("t3_locked_key", bus.keyinput, 64'h0);
        check("t3_locked_busy", 64'(bus.busy), 64'd0);
        check("t3_still_locked", 64'(bus.lockout), 64'd1);
        do_reset();
        check("t3_rst_lockout", 64'(bus.lockout), 64'd0);
        check("t3_rst_retry", 64'(bus.retry_cnt), 64'd0);

        // 5: restart at key bit 30, new frame opens with start+sen together
        send_hdr(8'hA5, 1'b0, 1'b0);
        send_key(K1, 30, 1'b0);
        send_frame(8'hA5, K3, crc8_ref(K3), 1'b0, 1'b1);
        check("t5_no_err", 64'(bus.load_err), 64'd0);
        tick();
        check("t5_valid", 64'(bus.key_valid), 64'd1);
        check("t5_keyinput", bus.keyinput, K3);
        check("t5_retry", 64'(bus.retry_cnt), 64'd0);

        // 6: reset at CRC bit 3 discards the frame and the earlier error count
        do_reset();
        send_hdr(8'h00, 1'b0, 1'b0);
        check("t6_pre_retry", 64'(bus.retry_cnt), 64'd1);
        send_hdr(8'hA5, 1'b0, 1'b0);
        send_key(K2, 64, 1'b0);
        send_crc(crc8_ref(K2), 3, 1'b0);
        rst = 1'b1;
        bus.key_sen = 1'b1;
        bus.key_sdi = crc8_ref(K2) >> 4 & 8'h01;
        tick();
        rst = 1'b0;
        bus.key_sen = 1'b0;
        check("t6_busy", 64'(bus.busy), 64'd0);
        check("t6_retry", 64'(bus.retry_cnt), 64'd0);
        check("t6_valid", 64'(bus.key_valid), 64'd0);
        check("t6_err", 64'(bus.load_err), 64'd0);
        check("t6_keyinput", bus.keyinput, 64'h0);
        send_frame(8'hA5, K2, crc8_ref(K2), 1'b1, 1'b0);
        tick();
        check("t6_commit_valid", 64'(bus.key_valid), 64'd1);
        check("t6_commit_key", bus.keyinput, K2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
